// File: rtl/imu_ctrl.sv
// imu_ctrl: IMU bring-up and periodic burst-read sequencer.
// The bring-up sequence reads WHO_AM_I and makes two config writes on the single-byte
// SPI master. After that, the block triggers burst reads on the multi-byte master while
// run is high, and unpacks each burst into six signed 16-bit samples.
module imu_ctrl #(
   parameter int unsigned BOOT_CYCLES = 1000,
   parameter int unsigned PERIOD      = 5000,
   parameter logic [7:0]  WHOAMI_ADDR = 8'h0F,
   parameter logic [7:0]  WHOAMI_VAL  = 8'h6C,
   parameter logic [7:0]  CFG1_ADDR   = 8'h10,
   parameter logic [7:0]  CFG1_VAL    = 8'h60,
   parameter logic [7:0]  CFG2_ADDR   = 8'h11,
   parameter logic [7:0]  CFG2_VAL    = 8'h60,
   parameter logic [7:0]  DATA_ADDR   = 8'h22
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               run,
   output logic [7:0]         s_addr,
   output logic [7:0]         s_wdata,
   output logic               s_read,
   output logic               s_enable,
   input  logic [7:0]         s_rdata,
   input  logic               s_done,
   output logic [7:0]         m_addr,
   output logic               m_enable,
   input  logic [95:0]        m_rdata,
   input  logic               m_done,
   output logic               bus_sel,
   output logic signed [15:0] gx,
   output logic signed [15:0] gy,
   output logic signed [15:0] gz,
   output logic signed [15:0] ax,
   output logic signed [15:0] ay,
   output logic signed [15:0] az,
   output logic               sample_valid,
   output logic               ready,
   output logic               id_err
);

   localparam int BOOT_W = (BOOT_CYCLES > 1) ? $clog2(BOOT_CYCLES) : 1;
   localparam int PER_W  = (PERIOD > 1) ? $clog2(PERIOD) : 1;
   localparam logic [BOOT_W-1:0] BOOT_LAST = BOOT_W'(BOOT_CYCLES - 1);
   localparam logic [PER_W-1:0]  PER_LAST  = PER_W'(PERIOD - 1);

   typedef enum logic [3:0] {
      BOOT, ID_REQ, ID_WAIT, CFG1_REQ, CFG1_WAIT, CFG2_REQ, CFG2_WAIT,
      IDLE, BURST_REQ, BURST_WAIT, ERROR
   } state_t;

   state_t              state_q, state_d;
   logic [BOOT_W-1:0]   boot_cnt_q, boot_cnt_d;
   logic [PER_W-1:0]    per_cnt_q, per_cnt_d;
   logic                first_q, first_d;
   logic                capture;
   logic                valid_q;
   logic signed [15:0]  gx_q, gy_q, gz_q, ax_q, ay_q, az_q;

   // Little-endian 16-bit sample k of the burst: bytes 2k (low) and 2k+1 (high).
   function automatic logic signed [15:0] sample16(input logic [95:0] d, input int k);
      return $signed(d[16*k +: 16]);
   endfunction

   // Control state, boot counter, period counter and first-burst flag.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q    <= BOOT;
         boot_cnt_q <= '0;
         per_cnt_q  <= '0;
         first_q    <= 1'b1;
      end else begin
         state_q    <= state_d;
         boot_cnt_q <= boot_cnt_d;
         per_cnt_q  <= per_cnt_d;
         first_q    <= first_d;
      end
   end

   // Next-state logic. The period counter saturates at PERIOD-1, so a slow burst
   // starts the next one right after its m_done instead of overlapping it.
   always_comb begin
      state_d    = state_q;
      boot_cnt_d = boot_cnt_q;
      per_cnt_d  = per_cnt_q;
      first_d    = first_q;
      case (state_q)
         BOOT: begin
            if (boot_cnt_q == BOOT_LAST) state_d = ID_REQ;
            else boot_cnt_d = boot_cnt_q + BOOT_W'(1);
         end
         ID_REQ:    state_d = ID_WAIT;
         ID_WAIT: begin
            if (s_done) state_d = (s_rdata == WHOAMI_VAL) ? CFG1_REQ : ERROR;
         end
         CFG1_REQ:  state_d = CFG1_WAIT;
         CFG1_WAIT: if (s_done) state_d = CFG2_REQ;
         CFG2_REQ:  state_d = CFG2_WAIT;
         CFG2_WAIT: if (s_done) state_d = IDLE;
         IDLE: begin
            if (run && (first_q || per_cnt_q == PER_LAST)) state_d = BURST_REQ;
         end
         BURST_REQ: state_d = BURST_WAIT;
         BURST_WAIT: begin
            if (m_done) state_d = (run && per_cnt_q == PER_LAST) ? BURST_REQ : IDLE;
         end
         ERROR:     state_d = ERROR;
         default:   state_d = BOOT;
      endcase

      // first_q re-arms while run is low so a rising run triggers a burst at once.
      if (!run) begin
         per_cnt_d = '0;
         first_d   = 1'b1;
      end else if (state_d == BURST_REQ) begin
         per_cnt_d = '0;
         first_d   = 1'b0;
      end else if ((state_q == IDLE || state_q == BURST_REQ || state_q == BURST_WAIT) &&
                   per_cnt_q != PER_LAST) begin
         per_cnt_d = per_cnt_q + PER_W'(1);
      end
   end

   // Outputs decoded from state. The REQ and WAIT states share the address and data
   // values, so they stay stable until the done strobe.
   always_comb begin
      s_addr   = 8'h00;
      s_wdata  = 8'h00;
      s_read   = 1'b0;
      s_enable = 1'b0;
      m_enable = 1'b0;
      bus_sel  = 1'b0;
      ready    = 1'b0;
      id_err   = 1'b0;
      case (state_q)
         ID_REQ, ID_WAIT: begin
            s_addr   = WHOAMI_ADDR;
            s_read   = 1'b1;
            s_enable = (state_q == ID_REQ);
         end
         CFG1_REQ, CFG1_WAIT: begin
            s_addr   = CFG1_ADDR;
            s_wdata  = CFG1_VAL;
            s_enable = (state_q == CFG1_REQ);
         end
         CFG2_REQ, CFG2_WAIT: begin
            s_addr   = CFG2_ADDR;
            s_wdata  = CFG2_VAL;
            s_enable = (state_q == CFG2_REQ);
         end
         IDLE, BURST_REQ, BURST_WAIT: begin
            bus_sel  = 1'b1;
            ready    = 1'b1;
            m_enable = (state_q == BURST_REQ);
         end
         ERROR:   id_err = 1'b1;
         default: ;
      endcase
   end

   assign capture = (state_q == BURST_WAIT) && m_done;

   // Samples are captured only on the m_done cycle, because the burst master clears
   // its rdata afterwards. The valid pulse follows one cycle later with the new data.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         valid_q <= 1'b0;
         gx_q    <= '0;
         gy_q    <= '0;
         gz_q    <= '0;
         ax_q    <= '0;
         ay_q    <= '0;
         az_q    <= '0;
      end else begin
         valid_q <= capture;
         if (capture) begin
            gx_q <= sample16(m_rdata, 0);
            gy_q <= sample16(m_rdata, 1);
            gz_q <= sample16(m_rdata, 2);
            ax_q <= sample16(m_rdata, 3);
            ay_q <= sample16(m_rdata, 4);
            az_q <= sample16(m_rdata, 5);
         end
      end
   end

   assign m_addr       = DATA_ADDR;
   assign sample_valid = valid_q;
   assign gx           = gx_q;
   assign gy           = gy_q;
   assign gz           = gz_q;
   assign ax           = ax_q;
   assign ay           = ay_q;
   assign az           = az_q;

endmodule
